ita_output_stage: RTL and testbench

//   Parametrised output stage for ITA that merges the FIFO controller, the output FIFO and the output controller.
//   It buffers post-activation rows from the pipeline and issues an early almost-full so the controller can stop issuing calc_en.
//   It serialises each N*WI row into BEATS narrower beats on a valid/ready port.
//   It adds flush, sticky overflow detection and a clearable high-watermark as real outputs.

---
 rtl/ita_output_stage.sv | 149 ++++++++++++++
 tb/tb_ita_output_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ita_output_stage.sv
// ITA output stage: row FIFO with early almost-full, per-row beat serialiser,
// synchronous flush, sticky overflow and a clearable usage high-watermark.
module ita_output_stage #(
   parameter int unsigned N         = 16,
   parameter int unsigned WI        = 8,
   parameter int unsigned DEPTH     = 12,
   parameter int unsigned BEATS     = 1,
   parameter int unsigned AF_MARGIN = 10
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           flush_i,
   input  logic                           push_i,
   input  logic [N*WI-1:0]                data_i,
   output logic                           almost_full_o,
   output logic                           full_o,
   output logic                           valid_o,
   input  logic                           ready_i,
   output logic [N*WI/BEATS-1:0]          oup_o,
   output logic                           last_beat_o,
   output logic [$clog2(DEPTH+1)-1:0]     usage_o,
   output logic [$clog2(DEPTH+1)-1:0]     usage_max_o,
   input  logic                           clr_max_i,
   output logic                           overflow_o
);

   localparam int unsigned ROW_W    = N * WI;
   localparam int unsigned BEAT_W   = ROW_W / ((BEATS == 0) ? 1 : BEATS);
   localparam int unsigned UW       = $clog2(DEPTH + 1);
   localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned BW       = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned AF_LEVEL = DEPTH - AF_MARGIN;

   // Elaboration-time parameter guards
   if (N == 0 || WI == 0) begin : g_bad_row
      $fatal(1, "ita_output_stage: N and WI must be non-zero");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $fatal(1, "ita_output_stage: DEPTH must be >= 2");
   end
   if (BEATS == 0 || (N % ((BEATS == 0) ? 1 : BEATS)) != 0) begin : g_bad_beats
      $fatal(1, "ita_output_stage: BEATS must divide N");
   end
   if (AF_MARGIN >= DEPTH) begin : g_bad_margin
      $fatal(1, "ita_output_stage: AF_MARGIN must be < DEPTH");
   end

   logic [ROW_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [BW-1:0]    beat_q, beat_d;
   logic [UW-1:0]    usage_q, usage_d;
   logic [UW-1:0]    usage_max_q, usage_max_d;
   logic             overflow_q, overflow_d;

   logic             valid, full, last, fire, pop, push_ok, wr_en;
   logic [ROW_W-1:0] head_row;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Handshake and acceptance decode, all from registered state
   assign valid    = (usage_q != '0);
   assign full     = (usage_q == UW'(DEPTH));
   assign last     = (beat_q == BW'(BEATS - 1));
   assign fire     = valid & ready_i;
   assign pop      = fire & last;
   assign push_ok  = push_i & (~full | pop);
   assign wr_en    = push_ok & ~flush_i;
   assign head_row = mem_q[rd_ptr_q];

   // Next-state logic; flush overrides push and pop
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      beat_d      = beat_q;
      usage_d     = usage_q;
      overflow_d  = overflow_q;
      usage_max_d = usage_max_q;

      if (flush_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         beat_d     = '0;
         usage_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end
         if (push_i && !push_ok) begin
            overflow_d = 1'b1;
         end
         if (fire) begin
            beat_d = last ? '0 : beat_q + BW'(1);
         end
         if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         case ({push_ok, pop})
            2'b10:   usage_d = usage_q + UW'(1);
            2'b01:   usage_d = usage_q - UW'(1);
            default: usage_d = usage_q;
         endcase
      end

      if (clr_max_i) begin
         usage_max_d = usage_d;
      end else if (usage_d > usage_max_q) begin
         usage_max_d = usage_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         beat_q      <= '0;
         usage_q     <= '0;
         usage_max_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         beat_q      <= beat_d;
         usage_q     <= usage_d;
         usage_max_q <= usage_max_d;
         overflow_q  <= overflow_d;
      end
   end

   // Row storage has no reset: it is only read while usage is non-zero
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign valid_o       = valid;
   assign oup_o         = valid ? head_row[32'(beat_q) * BEAT_W +: BEAT_W] : '0;
   assign last_beat_o   = valid & last;
   assign full_o        = full;
   assign almost_full_o = (usage_q >= UW'(AF_LEVEL));
   assign usage_o       = usage_q;
   assign usage_max_o   = usage_max_q;
   assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_ita_output_stage.sv
// Bench for ita_output_stage: two configurations, row-queue reference model,
// expected beats scoreboarded on acceptance and consumed on each transfer.
module tb_ita_output_stage;

   localparam int unsigned ROW_W = 128;

   typedef struct {
      logic [ROW_W-1:0] data;
      logic             last;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;
   bit          done [2];

   task automatic chk(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_cfg
      localparam int unsigned DEPTH = (g == 0) ? 12 : 5;
      localparam int unsigned BEATS = (g == 0) ? 1 : 4;
      localparam int unsigned AFM   = (g == 0) ? 10 : 3;
      localparam int unsigned W     = ROW_W / BEATS;
      localparam int unsigned UW    = $clog2(DEPTH + 1);
      localparam logic [ROW_W-1:0] MASK = (W == ROW_W) ? '1 : ((ROW_W'(1) << W) - ROW_W'(1));

      logic             rst_n, flush, push, ready, clr;
      logic [ROW_W-1:0] data;
      logic             af, full, valid, last_beat, ovf;
      logic [W-1:0]     oup;
      logic [UW-1:0]    usage, umax;

      ita_output_stage #(
         .N(16), .WI(8), .DEPTH(DEPTH), .BEATS(BEATS), .AF_MARGIN(AFM)
      ) dut (
         .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .push_i(push), .data_i(data),
         .almost_full_o(af), .full_o(full), .valid_o(valid), .ready_i(ready),
         .oup_o(oup), .last_beat_o(last_beat), .usage_o(usage), .usage_max_o(umax),
         .clr_max_i(clr), .overflow_o(ovf)
      );

      beat_t sb [$];
      int    m_rows = 0;
      int    m_umax = 0;
      bit    m_ovf  = 1'b0;
      bit    fire, pop;

      task automatic c(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
         chk($sformatf("cfg%0d %s", g, nm), act, exp);
      endtask

      // Monitor + model: compare what the DUT shows now, then apply this cycle's inputs
      always @(negedge clk) begin
         if (!rst_n) begin
            sb.delete();
            m_rows = 0;
            m_umax = 0;
            m_ovf  = 1'b0;
            c("reset valid", ROW_W'(valid), '0);
            c("reset usage", ROW_W'(usage), '0);
            c("reset oup", ROW_W'(oup), '0);
         end else begin
            c("valid", ROW_W'(valid), ROW_W'(m_rows != 0));
            c("usage", ROW_W'(usage), ROW_W'(m_rows));
            c("full", ROW_W'(full), ROW_W'(m_rows == int'(DEPTH)));
            c("almost_full", ROW_W'(af), ROW_W'(m_rows >= int'(DEPTH - AFM)));
            c("overflow", ROW_W'(ovf), ROW_W'(m_ovf));
            c("usage_max", ROW_W'(umax), ROW_W'(m_umax));
            if (m_rows != 0) begin
               c("oup", ROW_W'(oup), sb[0].data);
               c("last_beat", ROW_W'(last_beat), ROW_W'(sb[0].last));
            end else begin
               c("idle oup", ROW_W'(oup), '0);
               c("idle last_beat", ROW_W'(last_beat), '0);
            end

            fire = (m_rows != 0) && ready;
            pop  = fire && sb[0].last;
            if (flush) begin
               sb.delete();
               m_rows = 0;
               m_ovf  = 1'b0;
            end else begin
               if (fire) void'(sb.pop_front());
               if (push) begin
                  if (m_rows < int'(DEPTH) || pop) begin
                     for (int b = 0; b < int'(BEATS); b++) begin
                        beat_t e;
                        e.data = (data >> (b * int'(W))) & MASK;
                        e.last = (b == int'(BEATS) - 1);
                        sb.push_back(e);
                     end
                     m_rows++;
                  end else begin
                     m_ovf = 1'b1;
                  end
               end
               if (pop) m_rows--;
            end
            m_umax = clr ? m_rows : ((m_rows > m_umax) ? m_rows : m_umax);
         end
      end

      task automatic cyc(input bit p, input logic [ROW_W-1:0] d, input bit r, input bit f, input bit cl);
         push = p; data = d; ready = r; flush = f; clr = cl;
         @(posedge clk);
         #1;
      endtask

      function automatic logic [ROW_W-1:0] rnd_row();
         return {$urandom, $urandom, $urandom, $urandom};
      endfunction

      task automatic drain();
         for (int i = 0; i < 200 && valid; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
         c("drain completes", ROW_W'(valid), '0);
      endtask

      initial begin
         logic [ROW_W-1:0] t4_row;
         bit               rdy_seq [5];
         rdy_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
         t4_row  = {{4{8'hDD}}, {4{8'hCC}}, {4{8'hBB}}, {4{8'hAA}}};
         rst_n = 1'b1; push = 1'b0; data = '0; ready = 1'b0; flush = 1'b0; clr = 1'b0;
         #1 rst_n = 1'b0;
         repeat (3) @(posedge clk);
         #1 rst_n = 1'b1;

         // Back-to-back stream with the consumer always ready
         for (int k = 1; k <= 16; k++) cyc(1'b1, ROW_W'(k), 1'b1, 1'b0, 1'b0);
         drain();

         // Fill with a stalled consumer, then one overflowing push, then flush
         cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
         for (int k = 0; k < int'(DEPTH); k++) cyc(1'b1, rnd_row(), 1'b0, 1'b0, 1'b0);
         cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
         cyc(1'b1, rnd_row(), 1'b0, 1'b0, 1'b0);
         cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
         cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

         // Full, then a push coinciding with the final-beat pop
         for (int k = 0; k < int'(DEPTH); k++) cyc(1'b1, rnd_row(), 1'b0, 1'b0, 1'b0);
         for (int b = 0; b < int'(BEATS); b++)
            cyc(b == int'(BEATS) - 1, rnd_row(), 1'b1, 1'b0, 1'b0);
         drain();

         // Beat ordering with a one-cycle stall
         cyc(1'b1, t4_row, 1'b0, 1'b0, 1'b1);
         for (int i = 0; i < 5; i++) cyc(1'b0, '0, rdy_seq[i], 1'b0, 1'b0);
         drain();

         // Flush with a concurrent push while mid-row
         cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
         for (int k = 0; k < 3; k++) cyc(1'b1, rnd_row(), 1'b0, 1'b0, 1'b0);
         cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
         cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
         cyc(1'b1, rnd_row(), 1'b0, 1'b1, 1'b0);
         c("flush usage_max kept", ROW_W'(umax), ROW_W'(3));
         c("flush usage", ROW_W'(usage), '0);
         cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

         // Random traffic exercising pointer wrap
         for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 99) < 60, rnd_row(), $urandom_range(0, 1) == 1,
                $urandom_range(0, 99) == 0, $urandom_range(0, 99) < 4);

         // Asynchronous reset while a row is being transferred
         cyc(1'b1, rnd_row(), 1'b0, 1'b0, 1'b0);
         cyc(1'b1, rnd_row(), 1'b1, 1'b0, 1'b0);
         push = 1'b0; ready = 1'b1;
         rst_n = 1'b0;
         #1;
         c("async valid", ROW_W'(valid), '0);
         c("async oup", ROW_W'(oup), '0);
         c("async last_beat", ROW_W'(last_beat), '0);
         c("async usage", ROW_W'(usage), '0);
         c("async usage_max", ROW_W'(umax), '0);
         c("async overflow", ROW_W'(ovf), '0);
         c("async almost_full", ROW_W'(af), '0);
         c("async full", ROW_W'(full), '0);
         @(posedge clk);
         @(posedge clk);
         #1 rst_n = 1'b1;
         for (int i = 0; i < 20; i++)
            cyc($urandom_range(0, 1) == 1, rnd_row(), $urandom_range(0, 1) == 1, 1'b0, 1'b0);
         drain();
         done[g] = 1'b1;
      end
   end

   initial begin
      fork
         wait (done[0] && done[1]);
         #2_000_000;
      join_any
      disable fork;
      chk("bench completion", ROW_W'(done[0] && done[1]), ROW_W'(1));
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
